// File: rtl/cache_assoc_if.sv
// Request/response bundle for cache_assoc.
//   master: the requester (fetch unit side), drives en/wrt/i_flush/i_addr/i_data
//   slave : the cache, drives o_data/o_success/o_busy
interface cache_assoc_if #(
  parameter int SIZE_BLOCK = 32,
  parameter int BIT_TOTAL  = 24
) ();
  logic                  en;
  logic                  wrt;
  logic                  i_flush;
  logic [BIT_TOTAL-1:0]  i_addr;
  logic [SIZE_BLOCK-1:0] i_data;
  logic [SIZE_BLOCK-1:0] o_data;
  logic                  o_success;
  logic                  o_busy;

  modport master (
    output en, wrt, i_flush, i_addr, i_data,
    input  o_data, o_success, o_busy
  );

  modport slave (
    input  en, wrt, i_flush, i_addr, i_data,
    output o_data, o_success, o_busy
  );
endinterface

// File: rtl/cache_assoc.sv
// N-way set-associative block cache with true-LRU replacement and a
// sweeping invalidate-all flush engine.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cache_assoc_if.slave
//     en/wrt        request strobe, 1 = write/fill, 0 = read lookup
//     i_flush       start the invalidate-all sweep
//     i_addr/i_data request address and write data
//     o_data        read data (held except on accepted reads)
//     o_success     read hit / write accepted, one cycle after the request
//     o_busy        flush sweep in progress
//
// state   | meaning
// S_IDLE  | serving requests
// S_FLUSH | clearing one set per cycle, requests dropped
module cache_assoc #(
  parameter int SIZE_BLOCK = 32,
  parameter int BIT_TOTAL  = 24,
  parameter int BIT_INDEX  = 8,
  parameter int WAY        = 4
) (
  input  logic       clk,
  input  logic       rst,
  cache_assoc_if.slave bus
);

  localparam int SETS  = 1 << BIT_INDEX;
  localparam int TAG_W = BIT_TOTAL - BIT_INDEX;
  localparam int WAY_W = (WAY > 1) ? $clog2(WAY) : 1;
  // With WAY=1 the age field is a single constant-zero bit that synthesis drops.
  localparam int AGE_W = WAY_W;

  function automatic logic [WAY*AGE_W-1:0] age_init_f();
    logic [WAY*AGE_W-1:0] r;
    r = '0;
    for (int w = 0; w < WAY; w++) r[w*AGE_W +: AGE_W] = AGE_W'(w);
    return r;
  endfunction

  localparam logic [WAY*AGE_W-1:0] AGE_INIT = age_init_f();

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [BIT_INDEX-1:0]    flush_cnt_q, flush_cnt_d;
  logic                    busy_q, busy_d;
  logic                    success_q, success_d;
  logic [SIZE_BLOCK-1:0]   data_q, data_d;

  logic [SETS-1:0][WAY-1:0]            valid_q;
  logic [SETS-1:0][WAY-1:0][AGE_W-1:0] age_q;
  logic [TAG_W-1:0]                    tag_mem  [WAY][SETS];
  logic [SIZE_BLOCK-1:0]               data_mem [WAY][SETS];

  logic [BIT_INDEX-1:0]         idx;
  logic [TAG_W-1:0]             tag;
  logic [WAY-1:0]               valid_row;
  logic [WAY-1:0][AGE_W-1:0]    age_row;
  logic                         hit;
  logic [WAY_W-1:0]             hit_way;
  logic [WAY_W-1:0]             victim;
  logic [WAY_W-1:0]             acc_way;
  logic [AGE_W-1:0]             old_age;
  logic [WAY-1:0][AGE_W-1:0]    age_upd;
  logic                         acc, rd_hit, wr_acc;

  logic                         row_we;
  logic [BIT_INDEX-1:0]         row_idx;
  logic [WAY-1:0]               valid_row_d;
  logic [WAY-1:0][AGE_W-1:0]    age_row_d;

  // Lookup, victim selection and LRU age update for the addressed set.
  always_comb begin
    idx       = bus.i_addr[BIT_INDEX-1:0];
    tag       = bus.i_addr[BIT_TOTAL-1:BIT_INDEX];
    valid_row = valid_q[idx];
    age_row   = age_q[idx];

    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAY; w++) begin
      if (valid_row[w] && (tag_mem[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end

    // Default victim is the LRU way; any invalid way overrides it, and the
    // descending scan leaves the lowest-numbered invalid way selected.
    victim = '0;
    for (int w = 0; w < WAY; w++) begin
      if (age_row[w] == AGE_W'(WAY - 1)) victim = WAY_W'(w);
    end
    for (int w = WAY - 1; w >= 0; w--) begin
      if (!valid_row[w]) victim = WAY_W'(w);
    end

    acc_way = hit ? hit_way : victim;
    old_age = age_row[acc_way];
    for (int w = 0; w < WAY; w++) begin
      if (WAY_W'(w) == acc_way)     age_upd[w] = '0;
      else if (age_row[w] < old_age) age_upd[w] = age_row[w] + AGE_W'(1);
      else                           age_upd[w] = age_row[w];
    end
  end

  // Request acceptance, set write-back and control next-state.
  always_comb begin
    acc    = bus.en && !bus.i_flush && (state_q == S_IDLE);
    rd_hit = acc && !bus.wrt && hit;
    wr_acc = acc && bus.wrt;

    row_we      = 1'b0;
    row_idx     = idx;
    valid_row_d = valid_row;
    age_row_d   = age_upd;
    if (state_q == S_FLUSH) begin
      row_we      = 1'b1;
      row_idx     = flush_cnt_q;
      valid_row_d = '0;
      age_row_d   = AGE_INIT;
    end else if (rd_hit || wr_acc) begin
      row_we               = 1'b1;
      valid_row_d[acc_way] = 1'b1;
    end

    success_d = rd_hit || wr_acc;
    data_d    = data_q;
    if (acc && !bus.wrt) data_d = hit ? data_mem[hit_way][idx] : '0;

    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_flush) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
          busy_d      = 1'b1;
        end
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == '1) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      busy_q      <= 1'b0;
      success_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= '0;
      age_q       <= {SETS{AGE_INIT}};
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= busy_d;
      success_q   <= success_d;
      data_q      <= data_d;
      if (row_we) begin
        valid_q[row_idx] <= valid_row_d;
        age_q[row_idx]   <= age_row_d;
      end
    end
  end

  // Tag/data storage is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      tag_mem[acc_way][idx]  <= tag;
      data_mem[acc_way][idx] <= bus.i_data;
    end
  end

  assign bus.o_data    = data_q;
  assign bus.o_success = success_q;
  assign bus.o_busy    = busy_q;

endmodule

// File: tb/tb_cache_assoc.sv
module tb_cache_assoc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_assoc_if #(.SIZE_BLOCK(32), .BIT_TOTAL(24)) bus4 ();
  cache_assoc_if #(.SIZE_BLOCK(32), .BIT_TOTAL(24)) bus1 ();

  cache_assoc #(.SIZE_BLOCK(32), .BIT_TOTAL(24), .BIT_INDEX(8), .WAY(4)) u_dut (
    .clk(clk), .rst(rst), .bus(bus4)
  );
  cache_assoc #(.SIZE_BLOCK(32), .BIT_TOTAL(24), .BIT_INDEX(8), .WAY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        en;
    logic        wrt;
    logic [23:0] addr;
    logic [31:0] data;
    logic        exp_succ;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 ns after the following rising edge.
  task automatic req(input logic en, input logic wrt, input logic fl,
                     input logic [23:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus4.en = en; bus4.wrt = wrt; bus4.i_flush = fl;
    bus4.i_addr = addr; bus4.i_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic req1(input logic en, input logic wrt,
                      input logic [23:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus1.en = en; bus1.wrt = wrt; bus1.i_flush = 1'b0;
    bus1.i_addr = addr; bus1.i_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic succ, input logic [31:0] data);
    chk({name, " success"}, {31'b0, bus4.o_success}, {31'b0, succ});
    chk({name, " data"}, bus4.o_data, data);
  endtask

  int busy_cnt;

  initial begin
    bus4.en = 0; bus4.wrt = 0; bus4.i_flush = 0; bus4.i_addr = '0; bus4.i_data = '0;
    bus1.en = 0; bus1.wrt = 0; bus1.i_flush = 0; bus1.i_addr = '0; bus1.i_data = '0;

    tbl[0]  = '{1'b1, 1'b1, 24'h000003, 32'hF,  1'b1, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 24'h000003, 32'h0,  1'b1, 32'hF};
    tbl[2]  = '{1'b1, 1'b0, 24'h000004, 32'h0,  1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 24'h000005, 32'hF,  1'b1, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 24'h000005, 32'hD,  1'b1, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 24'h000005, 32'h0,  1'b1, 32'hD};
    tbl[6]  = '{1'b1, 1'b1, 24'h000105, 32'h11, 1'b1, 32'hD};
    tbl[7]  = '{1'b1, 1'b1, 24'h000205, 32'h12, 1'b1, 32'hD};
    tbl[8]  = '{1'b1, 1'b1, 24'h000305, 32'h13, 1'b1, 32'hD};
    tbl[9]  = '{1'b1, 1'b0, 24'h000005, 32'h0,  1'b1, 32'hD};
    tbl[10] = '{1'b1, 1'b0, 24'h000105, 32'h0,  1'b1, 32'h11};
    tbl[11] = '{1'b1, 1'b0, 24'h000205, 32'h0,  1'b1, 32'h12};
    tbl[12] = '{1'b1, 1'b0, 24'h000305, 32'h0,  1'b1, 32'h13};
    tbl[13] = '{1'b0, 1'b0, 24'h000000, 32'h0,  1'b0, 32'h13};
    tbl[14] = '{1'b1, 1'b1, 24'h000100, 32'h1,  1'b1, 32'h13};
    tbl[15] = '{1'b1, 1'b1, 24'h000200, 32'h2,  1'b1, 32'h13};
    tbl[16] = '{1'b1, 1'b1, 24'h000300, 32'h3,  1'b1, 32'h13};
    tbl[17] = '{1'b1, 1'b1, 24'h000400, 32'h4,  1'b1, 32'h13};
    tbl[18] = '{1'b1, 1'b0, 24'h000100, 32'h0,  1'b1, 32'h1};
    tbl[19] = '{1'b1, 1'b1, 24'h000500, 32'h5,  1'b1, 32'h1};
    tbl[20] = '{1'b1, 1'b0, 24'h000200, 32'h0,  1'b0, 32'h0};
    tbl[21] = '{1'b1, 1'b0, 24'h000100, 32'h0,  1'b1, 32'h1};
    tbl[22] = '{1'b1, 1'b0, 24'h000300, 32'h0,  1'b1, 32'h3};
    tbl[23] = '{1'b1, 1'b0, 24'h000400, 32'h0,  1'b1, 32'h4};
    tbl[24] = '{1'b1, 1'b0, 24'h000500, 32'h0,  1'b1, 32'h5};
    // Access order is now 100,300,400,500 so 100 is LRU and gets evicted.
    tbl[25] = '{1'b1, 1'b1, 24'h000600, 32'h6,  1'b1, 32'h5};
    tbl[26] = '{1'b1, 1'b0, 24'h000100, 32'h0,  1'b0, 32'h0};
    tbl[27] = '{1'b1, 1'b0, 24'h000300, 32'h0,  1'b1, 32'h3};
    tbl[28] = '{1'b1, 1'b1, 24'h0000FF, 32'hAA, 1'b1, 32'h3};
    tbl[29] = '{1'b1, 1'b0, 24'h0000FF, 32'h0,  1'b1, 32'hAA};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0);
    chk("reset busy", {31'b0, bus4.o_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Direct-mapped build: same index, second fill replaces the first.
    req1(1'b1, 1'b1, 24'h000000, 32'hD);
    chk("way1 wr0 success", {31'b0, bus1.o_success}, 32'h1);
    req1(1'b1, 1'b1, 24'h000100, 32'hC);
    req1(1'b1, 1'b0, 24'h000000, 32'h0);
    chk("way1 rd0 success", {31'b0, bus1.o_success}, 32'h0);
    chk("way1 rd0 data", bus1.o_data, 32'h0);
    req1(1'b1, 1'b0, 24'h000100, 32'h0);
    chk("way1 rd100 success", {31'b0, bus1.o_success}, 32'h1);
    chk("way1 rd100 data", bus1.o_data, 32'hC);
    req1(1'b0, 1'b0, 24'h000000, 32'h0);

    for (int i = 0; i < 30; i++) begin
      req(tbl[i].en, tbl[i].wrt, 1'b0, tbl[i].addr, tbl[i].data);
      chk_out($sformatf("vec%0d", i), tbl[i].exp_succ, tbl[i].exp_data);
      chk($sformatf("vec%0d busy", i), {31'b0, bus4.o_busy}, 32'h0);
    end

    // Flush with a simultaneous read of a resident block: read is dropped.
    req(1'b1, 1'b0, 1'b1, 24'h000300, 32'h0);
    chk("flush start busy", {31'b0, bus4.o_busy}, 32'h1);
    chk_out("flush start", 1'b0, 32'hAA);
    busy_cnt = 1;
    for (int i = 0; i < 300; i++) begin
      req(1'b1, 1'b0, 1'b0, 24'h0000FF, 32'h0);
      chk_out($sformatf("busy rd%0d", i), 1'b0, 32'hAA);
      if (!bus4.o_busy) break;
      busy_cnt++;
    end
    chk("busy cycles", busy_cnt, 32'd256);

    req(1'b1, 1'b0, 1'b0, 24'h000300, 32'h0);
    chk_out("post flush set0", 1'b0, 32'h0);
    req(1'b1, 1'b0, 1'b0, 24'h0000FF, 32'h0);
    chk_out("post flush set255", 1'b0, 32'h0);
    req(1'b1, 1'b1, 1'b0, 24'h000300, 32'h77);
    chk_out("post flush wr", 1'b1, 32'h0);
    req(1'b1, 1'b0, 1'b0, 24'h000300, 32'h0);
    chk_out("post flush rd", 1'b1, 32'h77);

    // Reset in the middle of a sweep, before set 200 is reached.
    req(1'b1, 1'b1, 1'b0, 24'h0000C8, 32'h55);
    chk_out("fill200", 1'b1, 32'h77);
    req(1'b1, 1'b0, 1'b0, 24'h0000C8, 32'h0);
    chk_out("read200", 1'b1, 32'h55);
    req(1'b0, 1'b0, 1'b1, 24'h000000, 32'h0);
    chk("flush2 busy", {31'b0, bus4.o_busy}, 32'h1);
    repeat (10) req(1'b0, 1'b0, 1'b0, 24'h000000, 32'h0);
    chk("flush2 still busy", {31'b0, bus4.o_busy}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst busy", {31'b0, bus4.o_busy}, 32'h0);
    chk_out("midrst", 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req(1'b1, 1'b0, 1'b0, 24'h0000C8, 32'h0);
    chk_out("after rst set200", 1'b0, 32'h0);
    chk("after rst busy", {31'b0, bus4.o_busy}, 32'h0);
    req(1'b0, 1'b0, 1'b0, 24'h000000, 32'h0);
    chk_out("after rst idle", 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
